nios2_system_irq_ctrl: RTL and testbench



---
 rtl/nios2_system_irq_pkg.sv | 28 ++
 rtl/nios2_system_irq_prio_enc.sv | 25 ++
 rtl/nios2_system_irq_ctrl.sv | 111 +++++++++++
 tb/tb_nios2_system_irq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nios2_system_irq_pkg.sv
// Shared constants for the Nios II system interrupt controller:
// register word addresses, vector register layout and a vector packing helper.
`timescale 1ns/1ps
package nios2_system_irq_pkg;

    localparam int DATA_W           = 16;
    localparam int VEC_IDX_W        = 4;
    localparam int VECTOR_VALID_BIT = 15;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_PENDING = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_MODE    = 3'd3;
    localparam logic [2:0] ADDR_VECTOR  = 3'd4;
    localparam logic [2:0] ADDR_CONTROL = 3'd5;
    localparam logic [2:0] ADDR_SET     = 3'd6;

    // Packs the valid flag and source index into the VECTOR register layout
    function automatic logic [DATA_W-1:0] makeVector(input logic valid,
                                                     input logic [VEC_IDX_W-1:0] index);
        logic [DATA_W-1:0] v;
        v                   = '0;
        v[VECTOR_VALID_BIT] = valid;
        v[VEC_IDX_W-1:0]    = index;
        return v;
    endfunction

endpackage

// File: rtl/nios2_system_irq_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 (the interval timer) always wins.
`timescale 1ns/1ps
module nios2_system_irq_prio_enc
    import nios2_system_irq_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0]   i_req,
    output logic                 o_valid,
    output logic [VEC_IDX_W-1:0] o_index
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_index = VEC_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/nios2_system_irq_ctrl.sv
// Avalon-MM interrupt controller: latches level/edge requests, masks them,
// applies a global enable and drives one registered interrupt line to the CPU.
`timescale 1ns/1ps
module nios2_system_irq_ctrl
    import nios2_system_irq_pkg::*;
#(
    parameter int                 NUM_IRQ      = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_DEFAULT = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq
);

    logic [NUM_IRQ-1:0]   r_irq_q;
    logic [NUM_IRQ-1:0]   r_pending;
    logic [NUM_IRQ-1:0]   r_mask;
    logic [NUM_IRQ-1:0]   r_mode;
    logic                 r_enable;

    logic                 w_write;
    logic [NUM_IRQ-1:0]   w_wdata;
    logic [NUM_IRQ-1:0]   w_rise;
    logic [NUM_IRQ-1:0]   w_clr;
    logic [NUM_IRQ-1:0]   w_set;
    logic [NUM_IRQ-1:0]   w_pending_nxt;
    logic [NUM_IRQ-1:0]   w_masked;
    logic                 w_vec_valid;
    logic [VEC_IDX_W-1:0] w_vec_index;
    logic [DATA_W-1:0]    w_rdata;
    logic                 w_unused_wdata;

    assign w_write        = chipselect & ~write_n;
    assign w_wdata        = writedata[NUM_IRQ-1:0];
    assign w_unused_wdata = ^writedata;
    assign w_rise         = irq_in & ~r_irq_q;
    assign w_clr          = (w_write && address == ADDR_PENDING) ? w_wdata : '0;
    assign w_set          = (w_write && address == ADDR_SET) ? w_wdata : '0;
    assign w_masked       = r_pending & r_mask;

    // Level bits track the input; edge bits hold until cleared, with rise/set beating clear
    assign w_pending_nxt = (r_mode & ((r_pending & ~w_clr) | w_rise | w_set))
                         | (~r_mode & irq_in);

    nios2_system_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .i_req   (w_masked),
        .o_valid (w_vec_valid),
        .o_index (w_vec_index)
    );

    // Edge-detect history and pending latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_q   <= '0;
            r_pending <= '0;
        end else begin
            r_irq_q   <= irq_in;
            r_pending <= w_pending_nxt;
        end
    end

    // Software-writable configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask   <= '0;
            r_mode   <= EDGE_DEFAULT;
            r_enable <= 1'b0;
        end else if (w_write) begin
            case (address)
                ADDR_MASK:    r_mask   <= w_wdata;
                ADDR_MODE:    r_mode   <= w_wdata;
                ADDR_CONTROL: r_enable <= writedata[0];
                default:      ;
            endcase
        end
    end

    // Read mux; the bus reads every cycle regardless of chipselect
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_STATUS:  w_rdata = DATA_W'(w_masked);
            ADDR_PENDING: w_rdata = DATA_W'(r_pending);
            ADDR_MASK:    w_rdata = DATA_W'(r_mask);
            ADDR_MODE:    w_rdata = DATA_W'(r_mode);
            ADDR_VECTOR:  w_rdata = makeVector(w_vec_valid, w_vec_index);
            ADDR_CONTROL: w_rdata = {{(DATA_W-1){1'b0}}, r_enable};
            default:      w_rdata = '0;
        endcase
    end

    // Registered read data and interrupt line to the CPU
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= w_rdata;
            irq      <= r_enable & (|w_masked);
        end
    end

endmodule

// File: tb/tb_nios2_system_irq_ctrl.sv
// Self-checking bench for nios2_system_irq_ctrl: register reads are scoreboarded
// through a queue, irq timing is checked cycle by cycle.
`timescale 1ns/1ps
module tb_nios2_system_irq_ctrl;

    localparam int         NUM_IRQ  = 8;
    localparam logic [7:0] EDGE_DEF = 8'h24;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        writeN = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic [7:0]  irqIn = '0;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    logic        rdValid = 1'b0;
    logic        rdValidQ = 1'b0;
    logic [15:0] expQ[$];
    string       tagQ[$];

    nios2_system_irq_ctrl #(
        .NUM_IRQ      (NUM_IRQ),
        .EDGE_DEFAULT (EDGE_DEF)
    ) dut (
        .clk        (clk),
        .reset_n    (resetN),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (writeN),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irqIn),
        .irq        (irq)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Read issued this cycle produces readdata after the next rising edge
    always @(posedge clk) rdValidQ <= rdValid;

    // Scoreboard: pop expected read data when the DUT presents it
    always @(negedge clk) begin
        if (rdValidQ) begin
            if (expQ.size() == 0) begin
                checkOutput("rd_underflow", 16'd1, 16'd0);
            end else begin
                checkOutput(tagQ.pop_front(), readdata, expQ.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Bus write, held for one cycle starting on a falling edge
    task automatic applyStimulus(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        writeN     = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        writeN     = 1'b1;
    endtask

    // Bus read; expected value goes to the scoreboard
    task automatic readReg(input logic [2:0] a, input logic [15:0] expected, input string tag);
        address    = a;
        chipselect = 1'b1;
        writeN     = 1'b1;
        rdValid    = 1'b1;
        expQ.push_back(expected);
        tagQ.push_back(tag);
        @(negedge clk);
        chipselect = 1'b0;
        rdValid    = 1'b0;
    endtask

    initial begin
        // Reset and register defaults
        idle(3);
        checkOutput("reset_irq", {15'd0, irq}, 16'd0);
        checkOutput("reset_rdata", readdata, 16'h0000);
        resetN = 1'b1;
        idle(1);
        readReg(3'd0, 16'h0000, "rst_status");
        readReg(3'd1, 16'h0000, "rst_pending");
        readReg(3'd2, 16'h0000, "rst_mask");
        readReg(3'd3, {8'h00, EDGE_DEF}, "rst_mode");
        readReg(3'd4, 16'h0000, "rst_vector");
        readReg(3'd5, 16'h0000, "rst_control");
        readReg(3'd6, 16'h0000, "rst_set");
        readReg(3'd7, 16'h0000, "rst_rsvd");
        checkOutput("rst_irq_after", {15'd0, irq}, 16'd0);

        // Edge source 0: pulse, irq after two edges, cleared by W1C
        applyStimulus(3'd3, 16'h0001);
        applyStimulus(3'd2, 16'h0001);
        applyStimulus(3'd5, 16'h0001);
        irqIn = 8'h01;
        @(negedge clk);
        irqIn = 8'h00;
        checkOutput("e0_irq_lat1", {15'd0, irq}, 16'd0);
        @(negedge clk);
        checkOutput("e0_irq_lat2", {15'd0, irq}, 16'd1);
        idle(3);
        checkOutput("e0_irq_hold", {15'd0, irq}, 16'd1);
        readReg(3'd4, 16'h8000, "e0_vector");
        readReg(3'd0, 16'h0001, "e0_status");
        applyStimulus(3'd1, 16'h0001);
        checkOutput("e0_clr_lat1", {15'd0, irq}, 16'd1);
        @(negedge clk);
        checkOutput("e0_clr_lat2", {15'd0, irq}, 16'd0);
        readReg(3'd1, 16'h0000, "e0_pend_clr");

        // Level source 3: follows the input, W1C has no effect
        applyStimulus(3'd2, 16'h0008);
        irqIn = 8'h08;
        @(negedge clk);
        checkOutput("l3_irq_lat1", {15'd0, irq}, 16'd0);
        @(negedge clk);
        checkOutput("l3_irq_lat2", {15'd0, irq}, 16'd1);
        applyStimulus(3'd1, 16'h0008);
        idle(2);
        checkOutput("l3_w1c_irq", {15'd0, irq}, 16'd1);
        readReg(3'd1, 16'h0008, "l3_pending");
        irqIn = 8'h00;
        @(negedge clk);
        checkOutput("l3_drop_lat1", {15'd0, irq}, 16'd1);
        @(negedge clk);
        checkOutput("l3_drop_lat2", {15'd0, irq}, 16'd0);

        // Priority: bits 2 and 5
        applyStimulus(3'd3, 16'h0024);
        applyStimulus(3'd2, 16'h0024);
        irqIn = 8'h24;
        @(negedge clk);
        irqIn = 8'h00;
        idle(1);
        readReg(3'd4, 16'h8002, "pr_vec_2");
        applyStimulus(3'd1, 16'h0004);
        readReg(3'd4, 16'h8005, "pr_vec_5");
        applyStimulus(3'd2, 16'h0000);
        readReg(3'd4, 16'h0000, "pr_vec_none");
        readReg(3'd0, 16'h0000, "pr_status");
        readReg(3'd1, 16'h0020, "pr_pending");
        checkOutput("pr_irq_masked", {15'd0, irq}, 16'd0);

        // Edge bit 1: rise coincides with clear, rise wins
        applyStimulus(3'd1, 16'h00FF);
        applyStimulus(3'd3, 16'h0002);
        irqIn = 8'h02;
        applyStimulus(3'd1, 16'h0002);
        irqIn = 8'h00;
        readReg(3'd1, 16'h0002, "race_pending");
        applyStimulus(3'd1, 16'h0002);
        readReg(3'd1, 16'h0000, "race_cleared");

        // Software set on edge bit 4, enable gating
        applyStimulus(3'd5, 16'h0000);
        applyStimulus(3'd3, 16'h0010);
        applyStimulus(3'd2, 16'h0010);
        applyStimulus(3'd6, 16'h0010);
        applyStimulus(3'd6, 16'h0001);
        readReg(3'd1, 16'h0010, "set_pending");
        readReg(3'd0, 16'h0010, "set_status");
        readReg(3'd6, 16'h0000, "set_readback");
        readReg(3'd4, 16'h8004, "set_vector");
        checkOutput("set_irq_dis", {15'd0, irq}, 16'd0);
        applyStimulus(3'd5, 16'h0001);
        checkOutput("en_irq_lat1", {15'd0, irq}, 16'd0);
        @(negedge clk);
        checkOutput("en_irq_lat2", {15'd0, irq}, 16'd1);
        readReg(3'd5, 16'h0001, "en_control");

        // Reset mid-operation with an edge input held high
        irqIn  = 8'h04;
        resetN = 1'b0;
        #1;
        checkOutput("mid_rst_irq", {15'd0, irq}, 16'd0);
        idle(2);
        resetN = 1'b1;
        idle(1);
        readReg(3'd1, 16'h0004, "rel_pending");
        readReg(3'd3, {8'h00, EDGE_DEF}, "rel_mode");
        readReg(3'd2, 16'h0000, "rel_mask");
        applyStimulus(3'd2, 16'h0004);
        applyStimulus(3'd5, 16'h0001);
        @(negedge clk);
        checkOutput("rel_irq", {15'd0, irq}, 16'd1);
        irqIn = 8'h00;

        idle(3);
        checkOutput("queue_drain", 16'(expQ.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
